// File: rtl/lot_occupancy_tracker.sv
// Parking-lot occupancy counter fed by one-cycle inc/dec pulses.
// Saturates at 0 and CAPACITY with sticky errors, and keeps a lockstep BCD copy for the display.
module lot_occupancy_tracker #(
  parameter int CAPACITY = 16,
  localparam int CW = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          err_clr,
  output logic [CW-1:0] count,
  output logic [CW-1:0] avail,
  output logic          full,
  output logic          empty,
  output logic          changed,
  output logic          ovf_err,
  output logic          unf_err,
  output logic [3:0]    bcd_hun,
  output logic [3:0]    bcd_ten,
  output logic [3:0]    bcd_one
);

  localparam logic [CW-1:0] CAP = CW'(CAPACITY);

  logic          at_cap, at_zero;
  logic          do_inc, do_dec, ovf_evt, unf_evt;
  logic [CW-1:0] count_next, avail_next;

  assign at_cap  = (count == CAP);
  assign at_zero = (count == '0);
  // Simultaneous inc/dec nets to zero and never raises an error.
  assign do_inc  = inc & ~dec & ~at_cap;
  assign do_dec  = dec & ~inc & ~at_zero;
  assign ovf_evt = inc & ~dec & at_cap;
  assign unf_evt = dec & ~inc & at_zero;

  always_comb begin
    count_next = count;
    avail_next = avail;
    if (do_inc) begin
      count_next = count + 1'b1;
      avail_next = avail - 1'b1;
    end else if (do_dec) begin
      count_next = count - 1'b1;
      avail_next = avail + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      avail   <= CAP;
      full    <= 1'b0;
      empty   <= 1'b1;
      changed <= 1'b0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      count   <= count_next;
      avail   <= avail_next;
      full    <= (count_next == CAP);
      empty   <= (count_next == '0);
      changed <= do_inc | do_dec;
      ovf_err <= ovf_evt | (ovf_err & ~err_clr);
      unf_err <= unf_evt | (unf_err & ~err_clr);
    end
  end

  // Three cascaded decade digits; index 0 is the ones digit.
  logic [3:0] bcd_q    [3];
  logic [3:0] bcd_next [3];
  logic [2:0] inc_c, dec_c;

  assign inc_c[0] = do_inc;
  assign dec_c[0] = do_dec;

  for (genvar gi = 0; gi < 3; gi++) begin : g_digit
    if (gi < 2) begin : g_chain
      assign inc_c[gi+1] = inc_c[gi] & (bcd_q[gi] == 4'd9);
      assign dec_c[gi+1] = dec_c[gi] & (bcd_q[gi] == 4'd0);
    end

    always_comb begin
      bcd_next[gi] = bcd_q[gi];
      if (inc_c[gi])
        bcd_next[gi] = (bcd_q[gi] == 4'd9) ? 4'd0 : bcd_q[gi] + 4'd1;
      else if (dec_c[gi])
        bcd_next[gi] = (bcd_q[gi] == 4'd0) ? 4'd9 : bcd_q[gi] - 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) bcd_q[gi] <= 4'd0;
      else     bcd_q[gi] <= bcd_next[gi];
    end
  end

  assign bcd_one = bcd_q[0];
  assign bcd_ten = bcd_q[1];
  assign bcd_hun = bcd_q[2];

  bcd_matches_count: assert property (@(posedge clk) disable iff (rst)
    (32'(bcd_hun) * 100 + 32'(bcd_ten) * 10 + 32'(bcd_one)) == 32'(count));

endmodule
